// File: rtl/combinational_fp_multiplier_seq.sv
// Sequential single-precision multiplier: shift-add significand product,
// one-cycle normalise, valid/ready handshake on both sides.
module combinational_fp_multiplier_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] output_z,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [47:0] acc;
    logic [4:0]  cnt;
    logic [31:0] z_q;

    logic [23:0] a_sig;
    logic [23:0] b_sig;
    logic [47:0] pp;
    logic        sign_z;
    logic [7:0]  exp_z;
    logic [22:0] mant_z;
    logic [31:0] z_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = MULT;
            MULT: if (cnt == 5'd23) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign output_z  = z_q;

    assign a_sig = {1'b1, a_q[22:0]};
    assign b_sig = {1'b1, b_q[22:0]};
    assign pp    = {24'b0, a_sig} << cnt;

    // Exponent wraps modulo 256: the low byte of the 10-bit sum.
    assign sign_z = a_q[31] ^ b_q[31];
    assign exp_z  = a_q[30:23] + b_q[30:23] - 8'd127 + {7'b0, acc[47]};
    assign mant_z = acc[47] ? acc[46:24] : acc[45:23];

    always_comb begin
        z_nxt = {sign_z, exp_z, mant_z};
        if (a_q[30:23] == 8'd0 || b_q[30:23] == 8'd0)
            z_nxt = {sign_z, 31'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= 32'b0;
            b_q <= 32'b0;
            acc <= 48'b0;
            cnt <= 5'b0;
            z_q <= 32'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= input_a;
                        b_q <= input_b;
                        acc <= 48'b0;
                        cnt <= 5'b0;
                    end
                end
                MULT: begin
                    if (b_sig[cnt]) acc <= acc + pp;
                    if (cnt != 5'd23) cnt <= cnt + 5'd1;
                end
                NORM: z_q <= z_nxt;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_combinational_fp_multiplier_seq.sv
// Bench for combinational_fp_multiplier_seq: vector table, scoreboard queue,
// directed hold and mid-operation reset sequences.
module tb_combinational_fp_multiplier_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] output_z;
    logic        out_valid;
    logic        out_ready;

    combinational_fp_multiplier_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .input_a   (input_a),
        .input_b   (input_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .output_z  (output_z),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
    } vec_t;

    vec_t        vt[8];
    logic [31:0] sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference product straight from the number format definition.
    function automatic logic [31:0] ref_mul(input logic [31:0] a,
                                            input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic        s;
        s = a[31] ^ b[31];
        p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
            return {s, 31'b0};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (p[47]) return {s, e[7:0] + 8'd1, p[46:24]};
        return {s, e[7:0], p[45:23]};
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] z);
        @(negedge clk);
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
        input_a  = a;
        input_b  = b;
        in_valid = 1'b1;
        sb.push_back(z);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        input_a  = $urandom;
        input_b  = $urandom;
    endtask

    task automatic finish_op(input string nm, input int hold);
        int          cyc;
        logic [31:0] z0;
        logic [31:0] exp;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 40);
        chk({nm, "_latency"}, cyc, 32'd26);
        if (!out_valid) begin
            void'(sb.pop_front());
            return;
        end
        z0 = output_z;
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            input_a  = $urandom;
            input_b  = $urandom;
            @(negedge clk);
            chk({nm, "_hold_z"}, output_z, z0);
            chk({nm, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
            chk({nm, "_hold_ready"}, {31'b0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exp = sb.pop_front();
        chk(nm, output_z, exp);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({nm, "_ret_idle"}, {31'b0, in_ready}, 32'd1);
        chk({nm, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        vt[0] = '{32'h40000000, 32'h40400000, 32'h40C00000};
        vt[1] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000};
        vt[2] = '{32'hBF800000, 32'h40800000, 32'hC0800000};
        vt[3] = '{32'h00000000, 32'hC0000000, 32'h80000000};
        vt[4] = '{32'h3F800000, 32'h3F800000, 32'h3F800000};
        vt[5] = '{32'h40A00000, 32'h3E800000, 32'h3FA00000};
        vt[6] = '{32'hC0000000, 32'hC0000000, 32'h40800000};
        vt[7] = '{32'h3F800000, 32'h00400000, 32'h00000000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        input_a   = 32'h0;
        input_b   = 32'h0;
        #12;
        chk("rst_z", output_z, 32'h0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            start_op(vt[i].a, vt[i].b, vt[i].z);
            finish_op($sformatf("vec%0d", i), 0);
        end

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            start_op(ra, rb, ref_mul(ra, rb));
            finish_op($sformatf("rnd%0d", i), 0);
        end

        start_op(32'h40000000, 32'h40400000, 32'h40C00000);
        finish_op("hold", 10);

        start_op(32'h3FC00000, 32'h3FC00000, 32'h40100000);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_z", output_z, 32'h0);
        #2;
        rst_n = 1'b1;
        chk("postrst_ready", {31'b0, in_ready}, 32'd1);
        start_op(32'hBF800000, 32'h40800000, 32'hC0800000);
        finish_op("after_rst", 0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
